// File: rtl/soc_system_pio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : soc_system_pio_pkg
//  Brief    : Shared constants for the input PIO: register map, edge-type
//             selectors and timestamp counter width.
//  Revision : 1.0  initial release
// ============================================================================
package soc_system_pio_pkg;

  // Word addresses of the slave register map
  localparam logic [2:0] ADDR_DATA          = 3'd0;
  localparam logic [2:0] ADDR_IRQ_MASK      = 3'd1;
  localparam logic [2:0] ADDR_EDGE_CAP      = 3'd2;
  localparam logic [2:0] ADDR_TS_LO         = 3'd3;
  localparam logic [2:0] ADDR_TS_HI         = 3'd4;
  localparam logic [2:0] ADDR_CNT_LO        = 3'd5;
  localparam logic [2:0] ADDR_CNT_HI_SHADOW = 3'd6;
  localparam logic [2:0] ADDR_STATUS        = 3'd7;

  // Edge-type selectors for the EDGE_TYPE parameter
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Free-running timestamp counter width
  localparam int COUNTER_W = 64;

endpackage
`default_nettype wire

// File: rtl/pio_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module   : pio_edge_sync
//  Brief    : Two-flop synchronizer for asynchronous inputs plus a history
//             flop and per-bit edge detection (rising / falling / any).
//  Revision : 1.0  initial release
// ============================================================================
module pio_edge_sync
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int EDGE_TYPE = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] det_o
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] prev_q;

  // Metastability chain followed by a one-cycle history of the clean value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= in_port_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign sync_o = sync2_q;

  // prev resets to 0, so an input already high at reset release is seen as a rising edge
  generate
    if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
      assign det_o = ~sync2_q & prev_q;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign det_o = sync2_q ^ prev_q;
    end else begin : g_rise
      assign det_o = sync2_q & ~prev_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/soc_system_pio_input_ts.sv
`default_nettype none
// ============================================================================
//  Module   : soc_system_pio_input_ts
//  Brief    : Avalon-MM input PIO with sticky W1C edge capture, maskable
//             level IRQ and a 64-bit timestamp of the first captured edge.
//  Revision : 1.0  initial release
// ============================================================================
module soc_system_pio_input_ts
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int EDGE_TYPE = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0]     w_sync;
  logic [WIDTH-1:0]     w_det;
  logic                 w_rd;
  logic                 w_wr;
  logic                 w_wr_cap;
  logic [WIDTH-1:0]     w_clr;
  logic                 w_armed;
  logic [31:0]          w_rd_mux;

  logic [WIDTH-1:0]     cap_q,    cap_d;
  logic [WIDTH-1:0]     mask_q,   mask_d;
  logic [COUNTER_W-1:0] cnt_q;
  logic [COUNTER_W-1:0] ts_q,     ts_d;
  logic                 tsv_q,    tsv_d;
  logic [31:0]          shadow_q;
  logic [31:0]          readdata_q;
  logic                 irq_q;

  pio_edge_sync #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_edge_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_port_i (in_port),
    .sync_o    (w_sync),
    .det_o     (w_det)
  );

  assign w_rd     = chipselect & ~read_n;
  assign w_wr     = chipselect & ~write_n;
  assign w_wr_cap = w_wr && (address == ADDR_EDGE_CAP);
  assign w_clr    = w_wr_cap ? writedata[WIDTH-1:0] : '0;
  // Timestamp only re-arms once every surviving captured bit is gone
  assign w_armed  = ((cap_q & ~w_clr) == '0);

  // Next-state for capture, mask and timestamp; a new edge beats a same-cycle clear
  always_comb begin
    cap_d  = (cap_q & ~w_clr) | w_det;
    mask_d = (w_wr && (address == ADDR_IRQ_MASK)) ? writedata[WIDTH-1:0] : mask_q;
    ts_d   = ts_q;
    tsv_d  = tsv_q;
    if (w_armed && (w_det != '0)) begin
      ts_d  = cnt_q;
      tsv_d = 1'b1;
    end else if (w_wr_cap && (cap_d == '0)) begin
      tsv_d = 1'b0;
    end
  end

  // Read mux from current (pre-write) register values
  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA:          w_rd_mux[WIDTH-1:0] = w_sync;
      ADDR_IRQ_MASK:      w_rd_mux[WIDTH-1:0] = mask_q;
      ADDR_EDGE_CAP:      w_rd_mux[WIDTH-1:0] = cap_q;
      ADDR_TS_LO:         w_rd_mux = ts_q[31:0];
      ADDR_TS_HI:         w_rd_mux = ts_q[63:32];
      ADDR_CNT_LO:        w_rd_mux = cnt_q[31:0];
      ADDR_CNT_HI_SHADOW: w_rd_mux = shadow_q;
      ADDR_STATUS:        w_rd_mux[0] = tsv_q;
      default:            w_rd_mux = '0;
    endcase
  end

  // Register state, free-running counter, read pipeline and registered IRQ
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_q      <= '0;
      mask_q     <= '0;
      cnt_q      <= '0;
      ts_q       <= '0;
      tsv_q      <= 1'b0;
      shadow_q   <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      cap_q  <= cap_d;
      mask_q <= mask_d;
      cnt_q  <= cnt_q + 64'd1;
      ts_q   <= ts_d;
      tsv_q  <= tsv_d;
      irq_q  <= |(cap_d & mask_d);
      if (w_rd) begin
        readdata_q <= w_rd_mux;
        // Latch the high word with the low-word read so the pair is coherent
        if (address == ADDR_CNT_LO) begin
          shadow_q <= cnt_q[63:32];
        end
      end
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_soc_system_pio_input_ts.sv
`default_nettype none
// ============================================================================
//  Module   : tb_soc_system_pio_input_ts
//  Brief    : Directed self-checking bench for the input PIO. A rising-edge
//             instance (WIDTH 32) and an any-edge instance (WIDTH 8) share
//             the bus and input stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_soc_system_pio_input_ts;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] readdata_any;
  logic [31:0] in_port;
  logic        irq;
  logic        irq_any;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] rd_any;

  always #5 clk = ~clk;

  soc_system_pio_input_ts #(.WIDTH(32), .EDGE_TYPE(0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  soc_system_pio_input_ts #(.WIDTH(8), .EDGE_TYPE(2)) dut_any (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata_any),
    .in_port    (in_port[7:0]),
    .irq        (irq_any)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    @(negedge clk);
    d = readdata; rd_any = readdata_any;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] wd);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = wd;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic bus_rw(input logic [2:0] a, input logic [31:0] wd, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; read_n = 1'b0; writedata = wd;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1; writedata = '0;
  endtask

  // Hard stop if the sequence ever stalls
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, c, c2, t;
    reset_n = 1'b0; address = '0; chipselect = 1'b0; read_n = 1'b1;
    write_n = 1'b1; writedata = '0; in_port = '0;
    cycles(3);
    chk("reset_readdata", readdata, 0);
    chk("reset_irq", irq, 0);
    reset_n = 1'b1;
    cycles(10);

    // Idle: everything zero except the running counter
    bus_read(3'd0, d); chk("idle_data", d, 0);
    bus_read(3'd1, d); chk("idle_mask", d, 0);
    bus_read(3'd2, d); chk("idle_cap", d, 0);
    bus_read(3'd3, d); chk("idle_ts_lo", d, 0);
    bus_read(3'd4, d); chk("idle_ts_hi", d, 0);
    bus_read(3'd5, c); chk("idle_cnt_nonzero", (c != 0), 1);
    bus_read(3'd5, d); chk("idle_cnt_step", d - c, 2);
    bus_read(3'd6, d); chk("idle_shadow", d, 0);
    bus_read(3'd7, d); chk("idle_status", d, 0);
    chk("idle_irq", irq, 0);

    // Mask read-back, width truncation, and read+write collision
    bus_write(3'd1, 32'hFFFF_FFFF);
    bus_read(3'd1, d); chk("mask_rb", d, 32'hFFFF_FFFF);
    chk("mask_rb_w8", rd_any, 32'h0000_00FF);
    bus_rw(3'd1, 32'h1, d); chk("rw_prewrite", d, 32'hFFFF_FFFF);
    bus_read(3'd1, d); chk("mask_after_rw", d, 32'h1);

    // First rising edge on bit 0: ts = counter two edges after the sampling edge
    bus_read(3'd5, c);
    in_port[0] = 1'b1;
    cycles(2); chk("irq_before_cap", irq, 0);
    cycles(1); chk("irq_after_cap", irq, 1);
    bus_read(3'd0, d); chk("data_bit0", d, 32'h1);
    bus_read(3'd2, d); chk("cap_bit0", d, 32'h1);
    bus_read(3'd3, d); chk("ts_lo_first", d, c + 32'd3);
    bus_read(3'd4, d); chk("ts_hi_first", d, 0);
    bus_read(3'd7, d); chk("status_set", d, 1);
    bus_write(3'd3, 32'hDEAD_BEEF);
    bus_read(3'd3, d); chk("ro_write_ignored", d, c + 32'd3);

    // Second bit while not armed: timestamp holds
    in_port[1] = 1'b1;
    cycles(4);
    bus_read(3'd2, d); chk("cap_bits01", d, 32'h3);
    bus_read(3'd3, d); chk("ts_held", d, c + 32'd3);
    bus_write(3'd2, 32'h3);
    chk("irq_cleared", irq, 0);
    bus_read(3'd2, d); chk("cap_cleared", d, 0);
    bus_read(3'd7, d); chk("status_cleared", d, 0);

    // Falling inputs are ignored by the rising-edge instance
    in_port[1:0] = 2'b00;
    cycles(5);
    bus_read(3'd2, d); chk("cap_fall_ignored", d, 0);

    // Unmasked bit 1 captures and timestamps without raising irq
    bus_read(3'd5, c2);
    in_port[1] = 1'b1;
    cycles(4);
    bus_read(3'd2, d); chk("cap_bit1", d, 32'h2);
    chk("irq_unmasked", irq, 0);

    // Bit 0 edge detected in the very cycle a W1C of bit 0 lands
    in_port[0] = 1'b1;
    @(negedge clk);
    bus_write(3'd2, 32'h1);
    chk("irq_edge_wins", irq, 1);
    bus_read(3'd2, d); chk("cap_edge_wins", d, 32'h3);
    bus_read(3'd3, d); chk("ts_not_recaptured", d, c2 + 32'd3);
    bus_read(3'd7, d); chk("status_still_set", d, 1);

    // Counter near the 32-bit boundary: shadow stays coherent with the low read
    @(negedge clk);
    force dut.cnt_q = 64'h0000_0000_FFFF_FFFE;
    #1;
    release dut.cnt_q;
    bus_read(3'd5, d); chk("cnt_lo_wrap", d, 32'hFFFF_FFFF);
    bus_read(3'd6, d); chk("shadow_pre_wrap", d, 0);
    bus_read(3'd5, d); chk("cnt_lo_after_wrap", d, 32'h3);
    bus_read(3'd6, d); chk("shadow_after_wrap", d, 32'h1);

    // Any-edge instance: a 1->0 transition on bit 3 is captured
    in_port[3] = 1'b1;
    cycles(5);
    bus_write(3'd2, 32'hFF);
    bus_read(3'd2, d); chk("any_cap_cleared", rd_any, 0);
    in_port[3] = 1'b0;
    cycles(5);
    bus_read(3'd2, d);
    chk("any_cap_fall", rd_any, 32'h8);
    chk("rise_cap_no_fall", d, 0);
    bus_write(3'd1, 32'h8);
    chk("any_irq_set", irq_any, 1);
    bus_read(3'd2, d);
    t = rd_any;
    chk("any_rd_before_rst", t, 32'h8);

    // Asynchronous reset mid-cycle clears outputs immediately
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_irq_any", irq_any, 0);
    chk("rst_rd_any", readdata_any, 0);
    chk("rst_rd", readdata, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Inputs already high at release register as rising edges
    cycles(5);
    bus_read(3'd2, d);
    chk("post_rst_cap", d, 32'h3);
    chk("post_rst_cap_any", rd_any, 32'h3);
    bus_read(3'd7, d); chk("post_rst_status", d, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
